melody_sequencer: RTL and testbench



---
 rtl/melody_sequencer.sv | 99 +++++++++
 tb/tb_melody_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer: walks the melody ROM, timing each entry in ticks and driving a square-wave speaker
module melody_sequencer #(
  parameter int LAST_INDEX = 48,
  parameter bit LOOP       = 1'b0,
  parameter int SILENT_MAX = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        play,
  input  logic        stop,
  input  logic        tick,
  input  logic [19:0] rom_note,
  input  logic [4:0]  rom_duration,
  output logic [9:0]  rom_addr,
  output logic        speaker,
  output logic        busy,
  output logic        done
);
  localparam logic [9:0]  LAST = 10'(LAST_INDEX);
  localparam logic [19:0] SIL  = 20'(SILENT_MAX);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
  state_t      state, state_d;
  logic [19:0] note_q, note_d, half_cnt, half_d;
  logic [4:0]  dur_q, dur_d, tick_cnt, tick_d;
  logic [9:0]  addr_d;
  logic        spk_d, busy_d, done_d, silent, half_end, note_end, last;
  assign silent   = note_q <= SIL;
  assign half_end = half_cnt == note_q - 20'd1;
  assign note_end = tick && tick_cnt == dur_q - 5'd1;
  assign last     = rom_addr == LAST;
  always_comb begin
    state_d = state;
    note_d  = note_q;
    dur_d   = dur_q;
    tick_d  = tick_cnt;
    half_d  = half_cnt;
    addr_d  = rom_addr;
    spk_d   = speaker;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      addr_d  = '0;
      spk_d   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          addr_d  = '0;
          spk_d   = 1'b0;
          state_d = play ? LOAD : IDLE;
        end
        LOAD: begin
          note_d  = rom_note;
          dur_d   = rom_duration == 5'd0 ? 5'd1 : rom_duration;
          tick_d  = '0;
          half_d  = '0;
          spk_d   = 1'b0;
          state_d = PLAY;
        end
        PLAY: begin
          if (note_end) begin
            spk_d   = 1'b0;
            addr_d  = last ? 10'd0 : rom_addr + 10'd1;
            state_d = (last && !LOOP) ? IDLE : LOAD;
            done_d  = last && !LOOP;
          end else begin
            tick_d = tick_cnt + 5'(tick);
            half_d = (silent || half_end) ? 20'd0 : half_cnt + 20'd1;
            spk_d  = !silent && (speaker ^ half_end);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      note_q   <= '0;
      dur_q    <= '0;
      tick_cnt <= '0;
      half_cnt <= '0;
      rom_addr <= '0;
      speaker  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      note_q   <= note_d;
      dur_q    <= dur_d;
      tick_cnt <= tick_d;
      half_cnt <= half_d;
      rom_addr <= addr_d;
      speaker  <= spk_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: random play/stop/tick traffic on a LOOP=0 and a LOOP=1 sequencer against a song-level model
module tb_melody_sequencer;
  localparam int LAST = 4;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        play = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [19:0] rom_n [LAST+1];
  logic [4:0]  rom_d [LAST+1];
  logic [9:0]  addr [2];
  logic [19:0] note_in [2];
  logic [4:0]  dur_in [2];
  logic        spk [2], busy [2], done [2];
  int          checks = 0, errors = 0, n_rst = 0, n_done = 0;
  bit          m_busy [2], m_load [2], m_done [2], m_spk [2];
  int          m_idx [2], m_k [2], m_ticks [2], m_note [2], m_dur [2];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_rom
    assign note_in[i] = addr[i] <= 10'(LAST) ? rom_n[addr[i]] : 20'd0;
    assign dur_in[i]  = addr[i] <= 10'(LAST) ? rom_d[addr[i]] : 5'd0;
  end

  melody_sequencer #(.LAST_INDEX(LAST), .LOOP(1'b0), .SILENT_MAX(1)) u0 (
    .clk(clk), .reset_n(reset_n), .play(play), .stop(stop), .tick(tick),
    .rom_note(note_in[0]), .rom_duration(dur_in[0]), .rom_addr(addr[0]),
    .speaker(spk[0]), .busy(busy[0]), .done(done[0]));
  melody_sequencer #(.LAST_INDEX(LAST), .LOOP(1'b1), .SILENT_MAX(1)) u1 (
    .clk(clk), .reset_n(reset_n), .play(play), .stop(stop), .tick(tick),
    .rom_note(note_in[1]), .rom_duration(dur_in[1]), .rom_addr(addr[1]),
    .speaker(spk[1]), .busy(busy[1]), .done(done[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_busy[u] = 0; m_load[u] = 0; m_done[u] = 0; m_spk[u] = 0;
      m_idx[u] = 0; m_k[u] = 0; m_ticks[u] = 0;
    end
  endtask

  // One clock edge of the song: idle -> fetch entry -> hold for dur ticks, tone from elapsed cycles
  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      m_done[u] = 0;
      if (stop) begin
        m_busy[u] = 0; m_load[u] = 0; m_idx[u] = 0; m_spk[u] = 0;
      end else if (!m_busy[u]) begin
        if (play) begin m_busy[u] = 1; m_load[u] = 1; end
      end else if (m_load[u]) begin
        m_note[u] = int'(rom_n[m_idx[u]]);
        m_dur[u] = rom_d[m_idx[u]] == 0 ? 1 : int'(rom_d[m_idx[u]]);
        m_ticks[u] = 0; m_k[u] = 0; m_load[u] = 0; m_spk[u] = 0;
      end else if (tick && m_ticks[u] + 1 == m_dur[u]) begin
        m_spk[u] = 0;
        if (m_idx[u] < LAST) begin
          m_idx[u]++; m_load[u] = 1;
        end else begin
          m_idx[u] = 0;
          if (u == 1) m_load[u] = 1;
          else begin m_busy[u] = 0; m_done[u] = 1; end
        end
      end else begin
        m_ticks[u] += int'(tick);
        m_k[u]++;
        m_spk[u] = m_note[u] > 1 ? ((m_k[u] / m_note[u]) % 2 == 1) : 1'b0;
      end
    end
  endtask

  task automatic compare(input string ph);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s_addr%0d", ph, u), 32'(addr[u]), 32'(m_idx[u]));
      check($sformatf("%s_spk%0d", ph, u), 32'(spk[u]), 32'(m_spk[u]));
      check($sformatf("%s_busy%0d", ph, u), 32'(busy[u]), 32'(m_busy[u]));
      check($sformatf("%s_done%0d", ph, u), 32'(done[u]), 32'(m_done[u]));
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i <= LAST; i++) begin
      rom_n[i] = 20'($urandom_range(9, 2));
      rom_d[i] = 5'($urandom_range(3, 0));
    end
    rom_n[1] = 20'd1;
    rom_d[2] = 5'd0;
  endtask

  initial begin
    fill_rom();
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare("reset");
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      play = $urandom_range(3) == 0;
      stop = $urandom_range(199) == 0;
      tick = $urandom_range(3) == 0;
      @(posedge clk);
      model_step();
      #1 compare("run");
      if (m_done[0]) n_done++;
      if (cyc > 1000 * (n_rst + 1) && m_busy[0] && !m_load[0] && m_k[0] > 2) begin
        #2 reset_n = 1'b0;
        model_reset();
        #1 compare("async");
        @(posedge clk);
        #1 compare("inrst");
        reset_n = 1'b1;
        n_rst++;
        fill_rom();
      end
    end
    check("async_resets", 32'(n_rst >= 2), 32'd1);
    check("song_ends", 32'(n_done > 0), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
